// File: rtl/data_bridge_queued.sv
`default_nettype none
// ============================================================================
//  Module      : data_bridge_queued
//  Description : Queued DV->DL write bridge with precharge/drive sequencing
//                and DL read capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_bridge_queued #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DV,
    input  logic [WIDTH-1:0] DataOut,
    input  logic             dv_valid,
    output logic             dv_ready,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic [WIDTH-1:0] DL_in,
    output logic [WIDTH-1:0] DL_out,
    output logic             dl_drive,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE     = 3'd1,
        S_DRIVE   = 3'd2,
        S_RPRE    = 3'd3,
        S_RSAMPLE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     fill_q;
    logic [WIDTH-1:0]   dv_q, oe_q, rd_data_q;
    logic               rd_valid_q;
    logic               push, pop, full, empty;

    assign full     = (fill_q == FILL_FULL);
    assign empty    = (fill_q == '0);
    assign push     = dv_valid & ~full;
    assign dv_ready = ~full;

    // Writes always take priority: a read is only accepted with an empty queue.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        rd_ack  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_PRE;
                    pop     = 1'b1;
                end else if (rd_req) begin
                    state_d = S_RPRE;
                    rd_ack  = 1'b1;
                end
            end
            S_PRE: begin
                state_d = S_DRIVE;
                hold_d  = HOLD_LAST;
            end
            S_DRIVE: begin
                if (hold_q == '0) begin
                    if (!empty) begin
                        state_d = S_PRE;
                        pop     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            S_RPRE:    state_d = S_RSAMPLE;
            S_RSAMPLE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            dv_q       <= '0;
            oe_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rd_valid_q <= (state_q == S_RSAMPLE);
            if (state_q == S_RSAMPLE) begin
                rd_data_q <= DL_in;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                {oe_q, dv_q} <= mem_q[rd_ptr_q];
                rd_ptr_q     <= rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_ONE;
                2'b01:   fill_q <= fill_q - FILL_ONE;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Storage needs no reset; only the pointers and fill count define validity.
    always_ff @(posedge CLK) begin
        if (!RESET && push) begin
            mem_q[wr_ptr_q] <= {DataOut, DV};
        end
    end

    // Only enabled zero bits pull the precharged line low.
    assign dl_drive = (state_q == S_DRIVE);
    assign DL_out   = dl_drive ? (dv_q | ~oe_q) : '1;
    assign busy     = (state_q != S_IDLE) || !empty;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
`default_nettype wire
